// File: rtl/td4_clock_ctrl.sv
// Clock-enable generator for the TD4 core: halt, push-button single-step, slow and fast auto-run.
// Optional button debounce is built only when CLKCTRL_DEBOUNCE_EN is defined.
module td4_clock_ctrl #(
    parameter int unsigned SLOW_DIV        = 10485760,
    parameter int unsigned FAST_DIV        = 1048576,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       step_btn,
    input  logic       halt_req,
    output logic       tick,
    output logic       clk_led,
    output logic [1:0] run_state
);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_STEP = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    localparam logic [31:0] SLOW_LAST = 32'(SLOW_DIV - 1);
    localparam logic [31:0] FAST_LAST = 32'(FAST_DIV - 1);

    if (SLOW_DIV < 2 || FAST_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("td4_clock_ctrl: SLOW_DIV/FAST_DIV must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [1:0]  mode_s1_q, mode_s2_q;
    logic        btn_s1_q, btn_s2_q;
    logic [1:0]  sync_vld_q;
    logic        btn_q, btn_prev_q, arm_q, edge_q, edge_d, rise;
    state_t      state_q, state_d;
    logic        fast_q, fast_d, chg;
    logic [31:0] presc_q, presc_d;
    logic        tick_q, tick_d, led_q, led_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s1_q  <= 2'b00;
            mode_s2_q  <= 2'b00;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            sync_vld_q <= 2'b00;
        end else begin
            mode_s1_q  <= mode;
            mode_s2_q  <= mode_s1_q;
            btn_s1_q   <= step_btn;
            btn_s2_q   <= btn_s1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

`ifdef CLKCTRL_DEBOUNCE_EN
    localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);
    logic        btn_db_q;
    logic [31:0] db_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db_q <= 1'b0;
            db_cnt_q <= '0;
        end else if (btn_s2_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_q <= btn_s2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 32'd1;
            end
        end else begin
            db_cnt_q <= '0;
        end
    end

    assign btn_q = btn_db_q;
`else
    assign btn_q = btn_s2_q;
`endif

    // A button held through reset must be seen released before a press can count.
    assign rise = btn_q & ~btn_prev_q & arm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HALT;
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fast_q  <= fast_d;
        end
    end

    always_comb begin
        state_d = S_HALT;
        fast_d  = mode_s2_q[0];
        unique case (mode_s2_q)
            2'b00:   state_d = S_HALT;
            2'b01:   state_d = S_STEP;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        chg     = (state_d != state_q) || (state_d == S_RUN && fast_d != fast_q);
        tick_d  = 1'b0;
        presc_d = presc_q;
        edge_d  = rise && (state_q == S_STEP) && (state_d == S_STEP);
        if (chg) begin
            presc_d = '0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (!halt_req) begin
                        if (presc_q == (fast_q ? FAST_LAST : SLOW_LAST)) begin
                            tick_d  = 1'b1;
                            presc_d = '0;
                        end else begin
                            presc_d = presc_q + 32'd1;
                        end
                    end
                end
                S_STEP: begin
                    tick_d  = edge_q;
                    presc_d = '0;
                end
                default: presc_d = '0;
            endcase
        end
        led_d = led_q ^ tick_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            led_q      <= 1'b0;
            btn_prev_q <= 1'b0;
            arm_q      <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            led_q      <= led_d;
            btn_prev_q <= btn_q;
            arm_q      <= arm_q | (sync_vld_q[1] & ~btn_s2_q);
            edge_q     <= edge_d;
        end
    end

    assign tick      = tick_q;
    assign clk_led   = led_q;
    assign run_state = state_q;

endmodule

// File: tb/tb_td4_clock_ctrl.sv
// Directed bench for td4_clock_ctrl: stimulus pushes expected tick cycles, a monitor pops and checks them.
module tb_td4_clock_ctrl;

`ifdef CLKCTRL_DEBOUNCE_EN
  localparam int BTN_LAT = 9;
`else
  localparam int BTN_LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       step_btn = 1'b0;
  logic       halt_req = 1'b0;
  logic       tick, clk_led;
  logic [1:0] run_state;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic        exp_led = 1'b0;
  logic        prev_tick = 1'b0;
  logic [31:0] mon_e;

  td4_clock_ctrl #(
    .SLOW_DIV(4),
    .FAST_DIV(2),
    .DEBOUNCE_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .step_btn(step_btn),
    .halt_req(halt_req),
    .tick(tick),
    .clk_led(clk_led),
    .run_state(run_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_tick(input int t);
    exp_q.push_back(32'(t));
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_led = 1'b0;
    end else if (tick) begin
      check("tick_gap", 32'(prev_tick), 32'd0);
      exp_led = ~exp_led;
      check("clk_led", 32'(clk_led), 32'(exp_led));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("tick_cycle", 32'(cyc), mon_e);
      end
    end
    prev_tick = tick;
  end

  // driver
  initial begin
    int t0, t1, t2, t3, p, q, r, s, b, u;

    wait_to(1);
    check("rst_tick", 32'(tick), 0);
    check("rst_led", 32'(clk_led), 0);
    check("rst_state", 32'(run_state), 0);
    wait_to(2);
    rst = 1'b0;
    wait_to(4);

    // slow run
    t0 = cyc;
    mode = 2'b10;
    push_tick(t0 + 7); push_tick(t0 + 11); push_tick(t0 + 15);
    wait_to(t0 + 3);
    check("run_state_slow", 32'(run_state), 32'd2);

    // slow -> fast with prescaler at 2 when the change is seen
    t1 = t0 + 15;
    wait_to(t1);
    mode = 2'b11;
    push_tick(t1 + 5); push_tick(t1 + 7); push_tick(t1 + 9);
    wait_to(t1 + 9);
    mode = 2'b10;
    push_tick(t1 + 11); push_tick(t1 + 16);

    // halt_req for 3 cycles at prescaler 1
    t2 = t1 + 16;
    wait_to(t2 + 1);
    halt_req = 1'b1;
    wait_to(t2 + 4);
    halt_req = 1'b0;
    push_tick(t2 + 7); push_tick(t2 + 11);

    // single step
    t3 = t2 + 11;
    wait_to(t3);
    mode = 2'b01;
    wait_to(t3 + 3);
    check("run_state_step", 32'(run_state), 32'd1);
    p = t3 + 5;
    wait_to(p);
    step_btn = 1'b1;
    push_tick(p + BTN_LAT);
    wait_to(p + 10);
    step_btn = 1'b0;
    q = p + 25;
    wait_to(q);
    step_btn = 1'b1;
    halt_req = 1'b1;
    push_tick(q + BTN_LAT);
    wait_to(q + 10);
    step_btn = 1'b0;
    halt_req = 1'b0;

    // halt mode discards presses
    r = q + 30;
    wait_to(r);
    mode = 2'b00;
    wait_to(r + 4);
    check("run_state_halt", 32'(run_state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b1;
      wait_to(cyc + 8);
      step_btn = 1'b0;
      wait_to(cyc + 8);
    end
    wait_to(cyc + 4);

    // press coinciding with the change into step
    s = cyc;
    mode = 2'b01;
    step_btn = 1'b1;
`ifdef CLKCTRL_DEBOUNCE_EN
    push_tick(s + 9);
`endif
    wait_to(s + 10);
    step_btn = 1'b0;
    wait_to(s + 22);

`ifdef CLKCTRL_DEBOUNCE_EN
    b = cyc;
    for (int i = 0; i < 4; i++) begin
      step_btn = (i % 2 == 0);
      wait_to(b + i + 1);
    end
    step_btn = 1'b1;
    push_tick(b + 4 + BTN_LAT);
    wait_to(b + 20);
`else
    b = cyc;
    step_btn = 1'b1;
    push_tick(b + BTN_LAT);
    wait_to(b + 10);
`endif
    step_btn = 1'b0;
    wait_to(cyc + 15);

    // fast run, then reset mid-count with a press held through reset
    u = cyc;
    mode = 2'b11;
    push_tick(u + 5); push_tick(u + 7); push_tick(u + 9);
    wait_to(u + 10);
    rst = 1'b1;
    mode = 2'b01;
    step_btn = 1'b1;
    wait_to(u + 11);
    check("mid_rst_tick", 32'(tick), 0);
    check("mid_rst_led", 32'(clk_led), 0);
    check("mid_rst_state", 32'(run_state), 0);
    wait_to(u + 12);
    rst = 1'b0;
    wait_to(u + 32);
    check("run_state_after_rst", 32'(run_state), 32'd1);
    step_btn = 1'b0;
    wait_to(cyc + 15);

    check("leftover_ticks", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
